// File: rtl/vdg_pkg.sv
// Shared definitions for the VDG pixel path: colour indices, mode encoding, latched byte payload
// and the character glyph table. LOWERCASE_EN selects the 128-glyph font.
package vdg_pkg;

    localparam int unsigned PIX_PER_LOAD = 8;
    localparam int unsigned FONT_ROWS    = 12;
    localparam int unsigned PIPE_DEPTH   = 2;
    localparam int unsigned COL_W        = 4;
    localparam int unsigned GLYPH_TOP    = 3;
`ifdef LOWERCASE_EN
    localparam int unsigned GLYPH_W      = 7;
`else
    localparam int unsigned GLYPH_W      = 6;
`endif

    localparam logic [COL_W-1:0] COL_GREEN    = 4'd0;
    localparam logic [COL_W-1:0] COL_YELLOW   = 4'd1;
    localparam logic [COL_W-1:0] COL_BLUE     = 4'd2;
    localparam logic [COL_W-1:0] COL_RED      = 4'd3;
    localparam logic [COL_W-1:0] COL_BUFF     = 4'd4;
    localparam logic [COL_W-1:0] COL_CYAN     = 4'd5;
    localparam logic [COL_W-1:0] COL_MAGENTA  = 4'd6;
    localparam logic [COL_W-1:0] COL_ORANGE   = 4'd7;
    localparam logic [COL_W-1:0] COL_BLACK    = 4'd8;
    localparam logic [COL_W-1:0] COL_DKGREEN  = 4'd9;
    localparam logic [COL_W-1:0] COL_DKORANGE = 4'd10;

    typedef enum logic [1:0] {MODE_ALPHA, MODE_SG4, MODE_GRES, MODE_GCOL} mode_t;

    typedef struct packed {
        logic [7:0] dd;
        mode_t      mode;
        logic       inv;
        logic       css;
        logic [3:0] row;
    } byte_lat_t;

    function automatic mode_t mode_of(input logic ang, input logic ans, input logic gm0);
        if (!ang) return ans ? MODE_SG4 : MODE_ALPHA;
        return gm0 ? MODE_GRES : MODE_GCOL;
    endfunction

    // 5x7 glyphs on cell rows 3..9 in bits [6:2]; undrawn codes show a hollow box.
    // The upper 64 codes reuse the shapes one scanline lower.
    function automatic logic [7:0] glyph_row(input logic [6:0] glyph, input logic [3:0] row);
        logic [34:0] bits;
        logic [34:0] sel;
        int          r;
        case (glyph[5:0])
            6'h00:   bits = {5'b01110, 5'b10001, 5'b10111, 5'b10101, 5'b10111, 5'b10000, 5'b01111};
            6'h01:   bits = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
            6'h02:   bits = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110};
            6'h03:   bits = {5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110};
            6'h20:   bits = '0;
            default: bits = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
        endcase
        r = int'(row) - int'(GLYPH_TOP) - int'(glyph[6]);
        if (r < 0 || r > 6) return 8'h00;
        sel = bits << (5 * r);
        return {1'b0, sel[34:30], 2'b00};
    endfunction

endpackage

// File: rtl/vdg_font_rom.sv
// Character font ROM: synchronous read of one 8-pixel glyph row, one enabled cycle of latency.
module vdg_font_rom
    import vdg_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic [GLYPH_W-1:0] glyph,
    input  logic [3:0]         row,
    output logic [7:0]         data
);

    always_ff @(negedge clk) begin
        if (en) begin
            data <= (row < 4'(FONT_ROWS)) ? glyph_row(7'(glyph), row) : 8'h00;
        end
    end

endmodule

// File: rtl/pixel_serializer.sv
// Byte-to-pixel serializer for the VDG: latch, decode/font lookup, 8-pixel colour shifter, and
// border/blank alignment. Define LOWERCASE_EN for the 128-glyph font with InV-only inversion.
module pixel_serializer
    import vdg_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       PixelEn,
    input  logic       Load,
    input  logic       Active,
    input  logic       BackPorch,
    input  logic [3:0] AlphaRow,
    input  logic [7:0] DD,
    input  logic       AnG,
    input  logic       AnS,
    input  logic       InV,
    input  logic [2:0] GM,
    input  logic       CSS,
    output logic [3:0] PixelOut,
    output logic       PixelValid
);

    byte_lat_t                  s0, s1;
    logic                       s0_vld, s1_vld;
    logic [7:0]                 rom_data;
    logic [GLYPH_W-1:0]         glyph;
    logic                       inv;
    logic [PIX_PER_LOAD-1:0][COL_W-1:0] vec, shift, shift_nxt;
    logic [COL_W-1:0]           fg, bg_new, bg_q, bg_nxt, head, pix_nxt;
    logic [7:0]                 pat;
    logic [1:0]                 blk;
    logic                       valid_nxt;
    logic [PIPE_DEPTH-1:0]      act_d, bp_d, ang_d, css_d;
    logic                       unused_gm;

    // Only GM[0] distinguishes the two graphics families at this stage.
    assign unused_gm = ^GM[2:1];

`ifdef LOWERCASE_EN
    assign glyph = s0.dd[6:0];
    assign inv   = s1.inv;
`else
    assign glyph = s0.dd[5:0];
    assign inv   = s1.inv ^ s1.dd[6];
`endif

    vdg_font_rom u_font_rom (
        .clk   (Clk),
        .en    (PixelEn),
        .glyph (glyph),
        .row   (s0.row),
        .data  (rom_data)
    );

    // Stage-1 decode: expand the latched byte into eight colour indices plus the drain colour.
    always_comb begin
        fg     = COL_BLACK;
        bg_new = COL_BLACK;
        pat    = '0;
        blk    = '0;
        vec    = '0;
        case (s1.mode)
            MODE_ALPHA: begin
                fg     = s1.css ? COL_ORANGE : COL_GREEN;
                bg_new = s1.css ? COL_DKORANGE : COL_DKGREEN;
                pat    = rom_data ^ {8{inv}};
            end
            MODE_SG4: begin
                fg  = {1'b0, s1.dd[6:4]};
                blk = (s1.row < 4'd6) ? s1.dd[3:2] : s1.dd[1:0];
                pat = {{4{blk[1]}}, {4{blk[0]}}};
            end
            MODE_GRES: begin
                fg     = s1.css ? COL_BUFF : COL_GREEN;
                bg_new = s1.css ? COL_BLACK : COL_DKGREEN;
                pat    = s1.dd;
            end
            default: bg_new = {1'b0, s1.css, 2'b00};
        endcase
        for (int i = 0; i < 8; i++) begin
            if (s1.mode == MODE_GCOL) vec[3'(i)] = {1'b0, s1.css, 2'(s1.dd >> (6 - 2 * (i / 2)))};
            else                      vec[3'(i)] = pat[3'(7 - i)] ? fg : bg_new;
        end
    end

    // A freshly decoded byte always replaces whatever is left in the shifter.
    always_comb begin
        if (s1_vld) begin
            head      = vec[0];
            shift_nxt = {bg_new, vec[7:1]};
            bg_nxt    = bg_new;
        end else begin
            head      = shift[0];
            shift_nxt = {bg_q, shift[7:1]};
            bg_nxt    = bg_q;
        end
    end

    always_comb begin
        pix_nxt   = head;
        valid_nxt = 1'b1;
        if (bp_d[PIPE_DEPTH-1]) begin
            pix_nxt   = COL_BLACK;
            valid_nxt = 1'b0;
        end else if (!act_d[PIPE_DEPTH-1]) begin
            pix_nxt   = ang_d[PIPE_DEPTH-1] ? (css_d[PIPE_DEPTH-1] ? COL_BUFF : COL_GREEN) : COL_BLACK;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(negedge Clk) begin
        if (Rst) begin
            s0         <= '0;
            s1         <= '0;
            s0_vld     <= 1'b0;
            s1_vld     <= 1'b0;
            shift      <= '0;
            bg_q       <= COL_BLACK;
            act_d      <= '0;
            bp_d       <= '0;
            ang_d      <= '0;
            css_d      <= '0;
            PixelOut   <= COL_BLACK;
            PixelValid <= 1'b0;
        end else if (PixelEn) begin
            s0_vld <= Load & Active;
            if (Load & Active) begin
                s0 <= '{dd: DD, mode: mode_of(AnG, AnS, GM[0]), inv: InV, css: CSS, row: AlphaRow};
            end
            s1         <= s0;
            s1_vld     <= s0_vld;
            shift      <= shift_nxt;
            bg_q       <= bg_nxt;
            act_d      <= {act_d[PIPE_DEPTH-2:0], Active};
            bp_d       <= {bp_d[PIPE_DEPTH-2:0], BackPorch};
            ang_d      <= {ang_d[PIPE_DEPTH-2:0], AnG};
            css_d      <= {css_d[PIPE_DEPTH-2:0], CSS};
            PixelOut   <= pix_nxt;
            PixelValid <= valid_nxt;
        end
    end

endmodule
